// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath: direction bit meanings,
// default playfield size and the ball FSM state encoding.
package pong_pkg;

  localparam logic RIGHT = 1'b0;
  localparam logic LEFT  = 1'b1;
  localparam logic UP    = 1'b1;
  localparam logic DOWN  = 1'b0;

  localparam int GAME_WIDTH_DEF  = 40;
  localparam int GAME_HEIGHT_DEF = 30;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/step_timer.sv
// Step-period counter for the ball; emits a one-cycle due strobe each period.
// Optional BALL_SPEEDUP_EN: the period shrinks by 1/8 on every left/right wall hit.
module step_timer #(
  parameter int BALL_SPEED = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hit_lr,
  output logic due
);

  localparam int PW = $clog2(BALL_SPEED + 1);

  logic [PW-1:0] count;
  logic [PW-1:0] period;

`ifdef BALL_SPEEDUP_EN
  localparam logic [PW-1:0] FLOOR = PW'(BALL_SPEED >> 2);

  logic [PW-1:0] shrunk;

  always_comb begin
    shrunk = period - (period >> 3);
    if (shrunk < FLOOR) shrunk = FLOOR;
  end

  // hit_lr arrives the cycle after the step, so the new period governs the next interval
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         period <= PW'(BALL_SPEED);
    else if (!run)   period <= PW'(BALL_SPEED);
    else if (hit_lr) period <= shrunk;
  end
`else
  logic unused_hit;

  assign period     = PW'(BALL_SPEED);
  assign unused_hit = hit_lr;
`endif

  assign due = run && (count == period - PW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              count <= '0;
    else if (!run || due) count <= '0;
    else                  count <= count + PW'(1);
  end

endmodule

// File: rtl/ball_motion.sv
// Moves the ball one tile per step period inside the playfield and raises
// wall-hit pulses. Optional BALL_SPEEDUP_EN is handled inside step_timer.
module ball_motion
  import pong_pkg::*;
#(
  parameter int GAME_WIDTH  = GAME_WIDTH_DEF,
  parameter int GAME_HEIGHT = GAME_HEIGHT_DEF,
  parameter int BALL_SPEED  = 1250000,
  parameter int START_X     = 20,
  parameter int START_Y     = 15
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Game_Active,
  input  logic                           i_HDir,
  input  logic                           i_VDir,
  output logic [$clog2(GAME_WIDTH)-1:0]  o_Ball_X,
  output logic [$clog2(GAME_HEIGHT)-1:0] o_Ball_Y,
  output logic                           o_Step,
  output logic                           o_Hit_Left,
  output logic                           o_Hit_Right,
  output logic                           o_Hit_Top,
  output logic                           o_Hit_Bottom
);

  localparam int XW = $clog2(GAME_WIDTH);
  localparam int YW = $clog2(GAME_HEIGHT);

  state_t          state, next_state;
  logic            run, due;
  logic [XW-1:0]   x_next;
  logic [YW-1:0]   y_next;
  logic            hit_l, hit_r, hit_t, hit_b;

  // dropping i_Game_Active stops the timer in the same cycle, suppressing a due step
  assign run = (state == RUN) && i_Game_Active;

  step_timer #(
    .BALL_SPEED(BALL_SPEED)
  ) u_step_timer (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .run    (run),
    .hit_lr (o_Hit_Left | o_Hit_Right),
    .due    (due)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_Game_Active)  next_state = RUN;
      RUN:     if (!i_Game_Active) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    x_next = o_Ball_X;
    y_next = o_Ball_Y;
    hit_l  = 1'b0;
    hit_r  = 1'b0;
    hit_t  = 1'b0;
    hit_b  = 1'b0;
    if (i_HDir == LEFT) begin
      if (o_Ball_X == '0) hit_l = 1'b1;
      else                x_next = o_Ball_X - XW'(1);
    end else begin
      if (o_Ball_X == XW'(GAME_WIDTH - 1)) hit_r = 1'b1;
      else                                 x_next = o_Ball_X + XW'(1);
    end
    if (i_VDir == UP) begin
      if (o_Ball_Y == '0) hit_t = 1'b1;
      else                y_next = o_Ball_Y - YW'(1);
    end else begin
      if (o_Ball_Y == YW'(GAME_HEIGHT - 1)) hit_b = 1'b1;
      else                                  y_next = o_Ball_Y + YW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Ball_X     <= XW'(START_X);
      o_Ball_Y     <= YW'(START_Y);
      o_Step       <= 1'b0;
      o_Hit_Left   <= 1'b0;
      o_Hit_Right  <= 1'b0;
      o_Hit_Top    <= 1'b0;
      o_Hit_Bottom <= 1'b0;
    end else begin
      o_Step       <= 1'b0;
      o_Hit_Left   <= 1'b0;
      o_Hit_Right  <= 1'b0;
      o_Hit_Top    <= 1'b0;
      o_Hit_Bottom <= 1'b0;
      if (!run) begin
        o_Ball_X <= XW'(START_X);
        o_Ball_Y <= YW'(START_Y);
      end else if (due) begin
        o_Ball_X     <= x_next;
        o_Ball_Y     <= y_next;
        o_Step       <= 1'b1;
        o_Hit_Left   <= hit_l;
        o_Hit_Right  <= hit_r;
        o_Hit_Top    <= hit_t;
        o_Hit_Bottom <= hit_b;
      end
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Randomized bench for ball_motion on an 8x6 field against an event-level model.
// With BALL_SPEEDUP_EN defined the bench uses a 64-cycle base period.
module tb_ball_motion;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int SX = 4;
  localparam int SY = 3;
`ifdef BALL_SPEEDUP_EN
  localparam int SPEED = 64;
`else
  localparam int SPEED = 4;
`endif

  logic       clk, rst, active, hdir, vdir;
  logic [2:0] bx, by;
  logic       step, hl, hr, ht, hb;

  ball_motion #(
    .GAME_WIDTH(W), .GAME_HEIGHT(H), .BALL_SPEED(SPEED), .START_X(SX), .START_Y(SY)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Game_Active(active), .i_HDir(hdir), .i_VDir(vdir),
    .o_Ball_X(bx), .o_Ball_Y(by), .o_Step(step),
    .o_Hit_Left(hl), .o_Hit_Right(hr), .o_Hit_Top(ht), .o_Hit_Bottom(hb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: ball either parked or running; a step fires once 'period' cycles have elapsed
  bit m_run;
  int m_elapsed, m_period, mx, my;
  bit m_step, m_hl, m_hr, m_ht, m_hb;

  task automatic model_reset();
    m_run = 0; m_elapsed = 0; m_period = SPEED; mx = SX; my = SY;
    m_step = 0; m_hl = 0; m_hr = 0; m_ht = 0; m_hb = 0;
  endtask

  task automatic model_edge();
    m_step = 0; m_hl = 0; m_hr = 0; m_ht = 0; m_hb = 0;
    if (!m_run || !active) begin
      m_run = active && !m_run;
      m_elapsed = 0; m_period = SPEED; mx = SX; my = SY;
    end else begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        m_step = 1;
        if (hdir) begin if (mx == 0) m_hl = 1; else mx--; end
        else      begin if (mx == W - 1) m_hr = 1; else mx++; end
        if (vdir) begin if (my == 0) m_ht = 1; else my--; end
        else      begin if (my == H - 1) m_hb = 1; else my++; end
`ifdef BALL_SPEEDUP_EN
        if (m_hl || m_hr) begin
          m_period = m_period - m_period / 8;
          if (m_period < SPEED / 4) m_period = SPEED / 4;
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("x", bx, mx);
    check("y", by, my);
    check("step", step, m_step);
    check("hit_left", hl, m_hl);
    check("hit_right", hr, m_hr);
    check("hit_top", ht, m_ht);
    check("hit_bottom", hb, m_hb);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1 compare_all();
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < 4 * SPEED + 8);
    if (!step) check("step_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    rst = 0;
  endtask

  int n;
  int ex[5] = '{3, 2, 1, 0, 0};
  int ey[5] = '{2, 1, 0, 0, 0};
  int et[5] = '{0, 0, 0, 1, 1};
  int el[5] = '{0, 0, 0, 0, 1};

  initial begin
    clk = 0; rst = 1; active = 0; hdir = 0; vdir = 0;
    model_reset();
    #12 compare_all();
    rst = 0;

    // first-step latency and straight diagonal move
    active = 1;
    tick();
    wait_step(n);
    check("t1_latency", n, SPEED);
    check("t1_x", bx, 5);
    check("t1_y", by, 4);
    tick();
    check("t1_step_width", step, 0);
    wait_step(n);
    check("t1_interval", n, SPEED - 1);
    check("t1_x2", bx, 6);
    check("t1_y2", by, 5);

    // up-left into the corner
    do_reset();
    hdir = 1; vdir = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wait_step(n);
      check("t2_x", bx, ex[i]);
      check("t2_y", by, ey[i]);
      check("t2_top", ht, et[i]);
      check("t2_left", hl, el[i]);
    end

    // down-right into the opposite corner, then two held steps
    hdir = 0; vdir = 0;
    for (int i = 0; i < 7; i++) wait_step(n);
    for (int i = 0; i < 2; i++) begin
      wait_step(n);
      check("t3_x", bx, W - 1);
      check("t3_y", by, H - 1);
      check("t3_right", hr, 1);
      check("t3_bottom", hb, 1);
      check("t3_left", hl, 0);
      check("t3_top", ht, 0);
    end

    // drop active in the step-due cycle
    repeat (m_period - 1) tick();
    active = 0;
    tick();
    check("t4_nostep", step, 0);
    check("t4_x", bx, SX);
    check("t4_y", by, SY);
    active = 1;
    tick();
    wait_step(n);
    check("t4_latency", n, SPEED);

    // asynchronous reset mid-interval
    tick();
    do_reset();

    // randomized run with occasional pauses, direction flips and resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 63) == 0) active = ~active;
      if ($urandom_range(0, 7) == 0) hdir = ~hdir;
      if ($urandom_range(0, 7) == 0) vdir = ~vdir;
      if ($urandom_range(0, 799) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
